// File: rtl/cam_resp_pkg.sv
// Shared types and constants for the CAM bus responder: FSM state encoding,
// key-length codes and the reset values of the operand registers.
package cam_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_RUN,
    ST_READY,
    ST_DATA_RUN,
    ST_OUT_HOLD,
    ST_ERROR
  } state_t;

  localparam logic [1:0] KLEN_128  = 2'b00;
  localparam logic [1:0] KLEN_192  = 2'b01;
  localparam logic [1:0] KLEN_256  = 2'b10;
  localparam logic [1:0] KLEN_RSVD = 2'b11;

  localparam logic [1:0] RST_K_LEN   = KLEN_256;
  localparam logic       RST_ENC_DEC = 1'b1;

endpackage

// File: rtl/cam_bus_responder_if.sv
// Host-side request/acknowledge bus plus cipher-core command bus of the responder.
// slave = responder view, master = host/core view.
interface cam_bus_responder_if #(parameter int KLEN_W = 2);
  logic [127:0]      cam_data_in;
  logic [255:0]      cam_key;
  logic [KLEN_W-1:0] cam_k_len;
  logic              cam_enc_dec;
  logic              cam_data_rdy;
  logic              cam_key_rdy;
  logic [127:0]      cam_data_out;
  logic              cam_data_acq;
  logic              cam_key_acq;
  logic              cam_output_rdy;
  logic              core_key_load;
  logic              core_start;
  logic [255:0]      core_key;
  logic [KLEN_W-1:0] core_k_len;
  logic [127:0]      core_data;
  logic              core_enc_dec;
  logic              core_done;
  logic [127:0]      core_result;
  logic              err;

  modport slave (
    input  cam_data_in, cam_key, cam_k_len, cam_enc_dec, cam_data_rdy, cam_key_rdy,
    input  core_done, core_result,
    output cam_data_out, cam_data_acq, cam_key_acq, cam_output_rdy,
    output core_key_load, core_start, core_key, core_k_len, core_data, core_enc_dec,
    output err
  );

  modport master (
    output cam_data_in, cam_key, cam_k_len, cam_enc_dec, cam_data_rdy, cam_key_rdy,
    output core_done, core_result,
    input  cam_data_out, cam_data_acq, cam_key_acq, cam_output_rdy,
    input  core_key_load, core_start, core_key, core_k_len, core_data, core_enc_dec,
    input  err
  );
endinterface

// File: rtl/cam_resp_timer.sv
// Timeout down-counter: loads TIMEOUT_CYCLES-1 on clear, counts while enabled,
// flags expiry on the last enabled cycle so err rises TIMEOUT_CYCLES after entry.
module cam_resp_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = LOAD_VAL;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expired_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/cam_bus_responder.sv
// Host-to-cipher-core responder: key load, block processing with a four-phase
// result handshake, sticky error. Optional timeout via CAM_RESP_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no valid key; waiting for cam_key_rdy
// KEY_RUN   | core expanding key; waiting for core_done
// READY     | key valid; waiting for a fresh cam_data_rdy request
// DATA_RUN  | core processing a block; waiting for core_done
// OUT_HOLD  | result presented; waiting for cam_data_rdy to drop
// ERROR     | reserved k_len or timeout; left only by reset
module cam_bus_responder
  import cam_resp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int KLEN_W         = 2
) (
  input logic               clk,
  input logic               rst,
  cam_bus_responder_if.slave bus
);

  state_t            state_q, state_d;
  logic [127:0]      data_out_q, data_out_d;
  logic [127:0]      core_data_q, core_data_d;
  logic [255:0]      core_key_q, core_key_d;
  logic [KLEN_W-1:0] k_len_q, k_len_d;
  logic              enc_dec_q, enc_dec_d;
  logic              key_load_q, key_load_d;
  logic              start_q, start_d;
  logic              key_acq_q, key_acq_d;
  logic              data_acq_q, data_acq_d;
  logic              out_rdy_q, out_rdy_d;
  logic              err_q, err_d;
  logic              armed_q, armed_d;
  logic              timer_clr, timer_en, timeout_hit;

  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    core_data_d = core_data_q;
    core_key_d  = core_key_q;
    k_len_d     = k_len_q;
    enc_dec_d   = enc_dec_q;
    key_load_d  = 1'b0;
    start_d     = 1'b0;
    key_acq_d   = 1'b0;
    data_acq_d  = 1'b0;
    out_rdy_d   = out_rdy_q;
    err_d       = err_q;
    // A block may only start after data_rdy has been seen low since the last one
    armed_d     = armed_q | ~bus.cam_data_rdy;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cam_key_rdy) begin
          if (bus.cam_k_len == KLEN_W'(KLEN_RSVD)) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            core_key_d = bus.cam_key;
            k_len_d    = bus.cam_k_len;
            key_load_d = 1'b1;
            timer_clr  = 1'b1;
            state_d    = ST_KEY_RUN;
          end
        end
      end
      ST_KEY_RUN: begin
        timer_en = 1'b1;
        if (bus.core_done) begin
          key_acq_d = 1'b1;
          state_d   = ST_READY;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_READY: begin
        if (!bus.cam_key_rdy) begin
          state_d = ST_IDLE;
        end else if (bus.cam_data_rdy && armed_q) begin
          core_data_d = bus.cam_data_in;
          enc_dec_d   = bus.cam_enc_dec;
          data_acq_d  = 1'b1;
          start_d     = 1'b1;
          armed_d     = 1'b0;
          timer_clr   = 1'b1;
          state_d     = ST_DATA_RUN;
        end
      end
      ST_DATA_RUN: begin
        timer_en = 1'b1;
        if (bus.core_done) begin
          data_out_d = bus.core_result;
          out_rdy_d  = 1'b1;
          state_d    = ST_OUT_HOLD;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_OUT_HOLD: begin
        if (!bus.cam_data_rdy) begin
          out_rdy_d = 1'b0;
          state_d   = ST_READY;
        end
      end
      ST_ERROR: begin
        out_rdy_d = 1'b0;
        err_d     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      data_out_q  <= '0;
      core_data_q <= '0;
      core_key_q  <= '0;
      k_len_q     <= KLEN_W'(RST_K_LEN);
      enc_dec_q   <= RST_ENC_DEC;
      key_load_q  <= 1'b0;
      start_q     <= 1'b0;
      key_acq_q   <= 1'b0;
      data_acq_q  <= 1'b0;
      out_rdy_q   <= 1'b0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      core_data_q <= core_data_d;
      core_key_q  <= core_key_d;
      k_len_q     <= k_len_d;
      enc_dec_q   <= enc_dec_d;
      key_load_q  <= key_load_d;
      start_q     <= start_d;
      key_acq_q   <= key_acq_d;
      data_acq_q  <= data_acq_d;
      out_rdy_q   <= out_rdy_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
    end
  end

`ifdef CAM_RESP_TIMEOUT_EN
  cam_resp_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (timer_clr),
    .enable_i  (timer_en),
    .expired_o (timeout_hit)
  );
`else
  // Without the timer the run states wait for core_done indefinitely
  logic unused_tmr;
  assign timeout_hit = 1'b0;
  assign unused_tmr  = ^{timer_clr, timer_en, (TIMEOUT_CYCLES > 0)};
`endif

  assign bus.cam_data_out   = data_out_q;
  assign bus.cam_data_acq   = data_acq_q;
  assign bus.cam_key_acq    = key_acq_q;
  assign bus.cam_output_rdy = out_rdy_q;
  assign bus.core_key_load  = key_load_q;
  assign bus.core_start     = start_q;
  assign bus.core_key       = core_key_q;
  assign bus.core_k_len     = k_len_q;
  assign bus.core_data      = core_data_q;
  assign bus.core_enc_dec   = enc_dec_q;
  assign bus.err            = err_q;

endmodule

// File: doc/cam_bus_responder.md
CAM_BUS_RESPONDER -- requirements
Module: cam_bus_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning maximum cycles to wait for core_done before error.
REQ-002 SHALL have parameter KLEN_W, default 2, meaning width of the key-length code.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 cam_data_in  input  128  plaintext/ciphertext block from host.
REQ-006 cam_key  input  256  key from host, left-aligned.
REQ-007 cam_k_len  input  2  key length: 00=128, 01=192, 10=256, 11=reserved.
REQ-008 cam_enc_dec  input  1  1=encrypt, 0=decrypt.
REQ-009 cam_data_rdy / cam_key_rdy  input  1 each  host request levels.
REQ-010 cam_data_out  output  128  result block.
REQ-011 cam_data_acq / cam_key_acq  output  1 each  single-cycle acceptance pulses.
REQ-012 cam_output_rdy  output  1  result-valid level.
REQ-013 core_key_load / core_start  output  1 each  single-cycle commands to cipher core.
REQ-014 core_key  output  256, core_k_len  output  2, core_data  output  128, core_enc_dec  output  1: registered operands to core.
REQ-015 core_done  input  1  core completion pulse; core_result  input  128  valid when core_done=1.
REQ-016 err  output  1  sticky error: reserved k_len or timeout.

Function
REQ-017 FSM states SHALL be IDLE, KEY_RUN, READY, DATA_RUN, OUT_HOLD, ERROR.
REQ-018 IDLE: cam_key_rdy=1 and k_len!=11 -> latch key/k_len into core_key/core_k_len, pulse core_key_load next cycle, go KEY_RUN.
REQ-019 IDLE: cam_key_rdy=1 and k_len=11 -> set err, go ERROR; no core_key_load.
REQ-020 KEY_RUN: core_done=1 -> pulse cam_key_acq exactly one cycle later, go READY.
REQ-021 READY: cam_key_rdy=0 -> key invalidated, go IDLE; this check has priority over cam_data_rdy in the same cycle.
REQ-022 READY: cam_data_rdy=1 and cam_key_rdy=1 -> latch cam_data_in/cam_enc_dec, pulse cam_data_acq and core_start in the same next cycle, go DATA_RUN.
REQ-023 DATA_RUN: core_done=1 -> register core_result into cam_data_out, assert cam_output_rdy next cycle, go OUT_HOLD.
REQ-024 OUT_HOLD: cam_output_rdy and cam_data_out SHALL hold until cam_data_rdy=0; then deassert cam_output_rdy next cycle, go READY (four-phase handshake).
REQ-025 OUT_HOLD: cam_key_rdy=0 SHALL NOT drop cam_output_rdy early; key invalidation applies on return to READY.
REQ-026 core_done outside KEY_RUN/DATA_RUN SHALL be ignored.
REQ-027 cam_data_rdy high on re-entry to READY SHALL NOT start a new block; requires a 0->1 transition seen after OUT_HOLD.
REQ-028 ERROR: all outputs except err idle; exit only by reset.
REQ-029 Request-to-core latency: 1 cycle; core_done-to-acq/output_rdy latency: 1 cycle.

Reset
REQ-030 On rst=0: state IDLE; cam_data_out=0, core_key=0, core_data=0, core_k_len=2'b10, core_enc_dec=1, all pulses/levels/err=0, timeout counter=0.
REQ-031 Reset mid-operation SHALL abort the transaction; a later core_done SHALL be ignored.

Configuration
REQ-032 CAM_RESP_TIMEOUT_EN defined: counter runs in KEY_RUN/DATA_RUN, cleared on entry; reaching TIMEOUT_CYCLES without core_done sets err, goes ERROR.
REQ-033 CAM_RESP_TIMEOUT_EN undefined: no counter; KEY_RUN/DATA_RUN wait indefinitely; err only from reserved k_len.

Structure
REQ-034 Package cam_resp_pkg SHALL hold the state enum, k_len codes (KLEN_128/192/256/RSVD) and reset constants.
REQ-035 Sub-module cam_resp_timer SHALL implement the timeout counter (clear, enable, expired), instantiated only under CAM_RESP_TIMEOUT_EN.

Verification
REQ-036 Key 256'h2bb5...51d8, k_len=10, core_done 5 cycles after core_key_load -> one-cycle cam_key_acq 1 cycle after core_done; state READY.
REQ-037 Two halves 128'hfd81...9483 then 128'hdfbf...8416, core returns 128'hA5.. -> each: cam_data_acq+core_start pulse; cam_output_rdy held until data_rdy drops; cam_data_out=core_result.
REQ-038 k_len=11 with key_rdy=1 -> err=1, no core_key_load, no cam_key_acq.
REQ-039 With CAM_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=8, core_done never sent -> err=1 exactly 8 cycles after core_start; without macro, err stays 0.
REQ-040 rst asserted in DATA_RUN, core_done 2 cycles after release -> cam_output_rdy stays 0, cam_data_out=0.
REQ-041 key_rdy and data_rdy fall together in OUT_HOLD -> output_rdy drops next cycle, FSM passes READY to IDLE.
